// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - return address stack with checkpoint/restore of pointer and count
//
// Purpose:
//    Circular return-address stack for branch prediction. A call pushes a
//    return target and a return pops it. The top pointer and the valid count
//    are exported so that branch checkpoint logic can capture them. After a
//    mispredict, restore_valid rewinds both values in a single cycle. Entries
//    are not rolled back on restore; only the pointer and count move.
//
// Ports:
//    CLK              in   clock, all state updates on the rising edge
//    RST              in   synchronous active-high reset
//    push_valid       in   push push_target (call)
//    push_target      in   return target to push
//    pop_valid        in   pop the top entry (return)
//    pop_target       out  current top-of-stack entry (combinational read)
//    pop_empty        out  high when count == 0
//    ras_index        out  current top pointer
//    ras_count        out  current valid-entry count
//    restore_valid    in   restore pointer/count, has priority over push/pop
//    restore_index    in   pointer to restore (clamped to RAS_ENTRIES-1)
//    restore_count    in   count to restore (clamped to RAS_ENTRIES)
//    overflow_pulse   out  previous cycle's push overwrote the oldest entry
//    underflow_pulse  out  previous cycle's pop happened at count 0
module ras_ckpt #(
   parameter int RAS_ENTRIES      = 8,
   parameter int RAS_TARGET_WIDTH = 31,
   localparam int IW = $clog2(RAS_ENTRIES),
   localparam int CW = $clog2(RAS_ENTRIES + 1)
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        push_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] push_target,
   input  logic                        pop_valid,
   output logic [RAS_TARGET_WIDTH-1:0] pop_target,
   output logic                        pop_empty,
   output logic [IW-1:0]               ras_index,
   output logic [CW-1:0]               ras_count,
   input  logic                        restore_valid,
   input  logic [IW-1:0]               restore_index,
   input  logic [CW-1:0]               restore_count,
   output logic                        overflow_pulse,
   output logic                        underflow_pulse
);

   localparam logic [IW-1:0] LAST = IW'(RAS_ENTRIES - 1);
   localparam logic [CW-1:0] FULL = CW'(RAS_ENTRIES);

   logic [RAS_TARGET_WIDTH-1:0] r_entries [RAS_ENTRIES];
   logic [IW-1:0]               r_ptr;
   logic [CW-1:0]               r_count;
   logic                        r_ovf;
   logic                        r_unf;

   logic [IW-1:0] w_inc;
   logic [IW-1:0] w_dec;
   logic [IW-1:0] w_ptr_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_wr_en;
   logic [IW-1:0] w_wr_idx;
   logic          w_ovf_nxt;
   logic          w_unf_nxt;

   // Explicit wrap at RAS_ENTRIES so non-power-of-two depths never address past the array
   assign w_inc = (r_ptr == LAST) ? '0 : r_ptr + IW'(1);
   assign w_dec = (r_ptr == '0) ? LAST : r_ptr - IW'(1);

   always_comb begin
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = r_count;
      w_wr_en   = 1'b0;
      w_wr_idx  = r_ptr;
      w_ovf_nxt = 1'b0;
      w_unf_nxt = 1'b0;
      if (restore_valid) begin
         w_ptr_nxt = (restore_index > LAST) ? LAST : restore_index;
         w_cnt_nxt = (restore_count > FULL) ? FULL : restore_count;
      end else if (push_valid && pop_valid) begin
         // Return-then-call: the popped slot is reused in place for the new target
         w_wr_en  = 1'b1;
         w_wr_idx = r_ptr;
         if (r_count == '0) begin
            w_cnt_nxt = CW'(1);
         end
      end else if (push_valid) begin
         w_ptr_nxt = w_inc;
         w_wr_en   = 1'b1;
         w_wr_idx  = w_inc;
         if (r_count == FULL) begin
            w_ovf_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_count + CW'(1);
         end
      end else if (pop_valid) begin
         // The pointer moves even when empty so a later push realigns with the caller
         w_ptr_nxt = w_dec;
         if (r_count == '0) begin
            w_unf_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ptr   <= LAST;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         for (int i = 0; i < RAS_ENTRIES; i++) begin
            r_entries[i] <= '0;
         end
      end else begin
         r_ptr   <= w_ptr_nxt;
         r_count <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
         if (w_wr_en) begin
            r_entries[w_wr_idx] <= push_target;
         end
      end
   end

   assign pop_target      = r_entries[r_ptr];
   assign pop_empty       = (r_count == '0);
   assign ras_index       = r_ptr;
   assign ras_count       = r_count;
   assign overflow_pulse  = r_ovf;
   assign underflow_pulse = r_unf;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - directed self-checking bench for ras_ckpt (depth 8 and depth 6)
module tb_ras_ckpt;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   // depth 8 instance
   logic        a_push_valid = 1'b0;
   logic [30:0] a_push_target = '0;
   logic        a_pop_valid = 1'b0;
   logic [30:0] a_pop_target;
   logic        a_pop_empty;
   logic [2:0]  a_ras_index;
   logic [3:0]  a_ras_count;
   logic        a_restore_valid = 1'b0;
   logic [2:0]  a_restore_index = '0;
   logic [3:0]  a_restore_count = '0;
   logic        a_ovf;
   logic        a_unf;

   // depth 6 instance
   logic        b_push_valid = 1'b0;
   logic [30:0] b_push_target = '0;
   logic        b_pop_valid = 1'b0;
   logic [30:0] b_pop_target;
   logic        b_pop_empty;
   logic [2:0]  b_ras_index;
   logic [2:0]  b_ras_count;
   logic        b_restore_valid = 1'b0;
   logic [2:0]  b_restore_index = '0;
   logic [2:0]  b_restore_count = '0;
   logic        b_ovf;
   logic        b_unf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   ras_ckpt #(.RAS_ENTRIES(8), .RAS_TARGET_WIDTH(31)) u_dut_a (
      .CLK(CLK), .RST(RST),
      .push_valid(a_push_valid), .push_target(a_push_target),
      .pop_valid(a_pop_valid), .pop_target(a_pop_target), .pop_empty(a_pop_empty),
      .ras_index(a_ras_index), .ras_count(a_ras_count),
      .restore_valid(a_restore_valid), .restore_index(a_restore_index),
      .restore_count(a_restore_count),
      .overflow_pulse(a_ovf), .underflow_pulse(a_unf)
   );

   ras_ckpt #(.RAS_ENTRIES(6), .RAS_TARGET_WIDTH(31)) u_dut_b (
      .CLK(CLK), .RST(RST),
      .push_valid(b_push_valid), .push_target(b_push_target),
      .pop_valid(b_pop_valid), .pop_target(b_pop_target), .pop_empty(b_pop_empty),
      .ras_index(b_ras_index), .ras_count(b_ras_count),
      .restore_valid(b_restore_valid), .restore_index(b_restore_index),
      .restore_count(b_restore_count),
      .overflow_pulse(b_ovf), .underflow_pulse(b_unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // one cycle on instance A, inputs released afterwards
   task automatic cyc_a(input logic psh, input logic [30:0] tgt, input logic pp,
                        input logic rv, input logic [2:0] ri, input logic [3:0] rc);
      a_push_valid = psh; a_push_target = tgt; a_pop_valid = pp;
      a_restore_valid = rv; a_restore_index = ri; a_restore_count = rc;
      step();
      a_push_valid = 1'b0; a_pop_valid = 1'b0; a_restore_valid = 1'b0;
   endtask

   task automatic cyc_b(input logic psh, input logic [30:0] tgt, input logic pp,
                        input logic rv, input logic [2:0] ri, input logic [2:0] rc);
      b_push_valid = psh; b_push_target = tgt; b_pop_valid = pp;
      b_restore_valid = rv; b_restore_index = ri; b_restore_count = rc;
      step();
      b_push_valid = 1'b0; b_pop_valid = 1'b0; b_restore_valid = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic chk_a(input string tag, input int idx, input int cnt, input int top);
      chk({tag, " idx"}, 32'(a_ras_index), 32'(idx));
      chk({tag, " cnt"}, 32'(a_ras_count), 32'(cnt));
      chk({tag, " top"}, 32'(a_pop_target), 32'(top));
   endtask

   initial begin
      // reset state, checked while RST is still held
      RST = 1'b1;
      step();
      step();
      chk_a("rst_a", 7, 0, 0);
      chk("rst_a empty", 32'(a_pop_empty), 32'd1);
      chk("rst_a ovf", 32'(a_ovf), 32'd0);
      chk("rst_a unf", 32'(a_unf), 32'd0);
      chk("rst_b idx", 32'(b_ras_index), 32'd5);
      RST = 1'b0;

      // depth 6: pointer walks 0..5 then wraps to 0, 7th push overwrites slot 0
      for (int i = 0; i < 7; i++) begin
         cyc_b(1'b1, 31'(32'h10 + i), 1'b0, 1'b0, 3'd0, 3'd0);
         chk($sformatf("b_push%0d idx", i), 32'(b_ras_index), 32'(i % 6));
         chk($sformatf("b_push%0d ovf", i), 32'(b_ovf), 32'(i == 6));
      end
      chk("b_full cnt", 32'(b_ras_count), 32'd6);
      chk("b_full top", 32'(b_pop_target), 32'h16);
      // out-of-range restore index and count clamp to the top slot and full count
      cyc_b(1'b0, '0, 1'b0, 1'b1, 3'd7, 3'd7);
      chk("b_clamp idx", 32'(b_ras_index), 32'd5);
      chk("b_clamp cnt", 32'(b_ras_count), 32'd6);
      chk("b_clamp top", 32'(b_pop_target), 32'h15);
      // decrement from 0 wraps to 5, not 7
      cyc_b(1'b0, '0, 1'b0, 1'b1, 3'd0, 3'd1);
      cyc_b(1'b0, '0, 1'b1, 1'b0, 3'd0, 3'd0);
      chk("b_wrapdec idx", 32'(b_ras_index), 32'd5);
      chk("b_wrapdec cnt", 32'(b_ras_count), 32'd0);

      // basic push/pop ordering
      do_reset();
      cyc_a(1'b1, 31'h100, 1'b0, 1'b0, 3'd0, 4'd0);
      cyc_a(1'b1, 31'h200, 1'b0, 1'b0, 3'd0, 4'd0);
      cyc_a(1'b1, 31'h300, 1'b0, 1'b0, 3'd0, 4'd0);
      chk_a("push3", 2, 3, 32'h300);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 3'd0, 4'd0);
      chk_a("pop1", 1, 2, 32'h200);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 3'd0, 4'd0);
      chk_a("pop2", 0, 1, 32'h100);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 3'd0, 4'd0);
      chk("pop3 empty", 32'(a_pop_empty), 32'd1);
      chk("pop3 idx", 32'(a_ras_index), 32'd7);
      chk("pop3 unf", 32'(a_unf), 32'd0);

      // underflow from reset
      do_reset();
      chk("unf pre top", 32'(a_pop_target), 32'd0);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 3'd0, 4'd0);
      chk("unf pulse", 32'(a_unf), 32'd1);
      chk_a("unf", 6, 0, 0);
      cyc_a(1'b0, '0, 1'b0, 1'b0, 3'd0, 4'd0);
      chk("unf clear", 32'(a_unf), 32'd0);

      // overflow: 9 pushes, pulse only after the 9th
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         cyc_a(1'b1, 31'(i), 1'b0, 1'b0, 3'd0, 4'd0);
         chk($sformatf("ovf push%0d", i), 32'(a_ovf), 32'(i == 9));
      end
      chk_a("ovf full", 0, 8, 9);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ovf pop%0d top", i), 32'(a_pop_target), 32'(9 - i));
         cyc_a(1'b0, '0, 1'b1, 1'b0, 3'd0, 4'd0);
         chk($sformatf("ovf pop%0d ovf", i), 32'(a_ovf), 32'd0);
      end
      chk("ovf drained empty", 32'(a_pop_empty), 32'd1);

      // checkpoint and restore
      do_reset();
      cyc_a(1'b1, 31'hA, 1'b0, 1'b0, 3'd0, 4'd0);
      cyc_a(1'b1, 31'hB, 1'b0, 1'b0, 3'd0, 4'd0);
      chk_a("ckpt capture", 1, 2, 32'hB);
      cyc_a(1'b1, 31'hC, 1'b0, 1'b0, 3'd0, 4'd0);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 3'd0, 4'd0);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 3'd0, 4'd0);
      chk_a("ckpt spec", 0, 1, 32'hA);
      cyc_a(1'b1, 31'hFF, 1'b1, 1'b1, 3'd1, 4'd2);
      chk_a("restore", 1, 2, 32'hB);
      chk("restore ovf", 32'(a_ovf), 32'd0);
      chk("restore unf", 32'(a_unf), 32'd0);
      // slot 2 still holds the speculative push; restore must not touch entries
      cyc_a(1'b0, '0, 1'b0, 1'b1, 3'd2, 4'd3);
      chk("restore slot2", 32'(a_pop_target), 32'hC);
      cyc_a(1'b0, '0, 1'b0, 1'b1, 3'd1, 4'd15);
      chk("restore cnt clamp", 32'(a_ras_count), 32'd8);
      cyc_a(1'b0, '0, 1'b0, 1'b1, 3'd1, 4'd2);

      // push + pop same cycle replaces top in place
      cyc_a(1'b1, 31'hD, 1'b1, 1'b0, 3'd0, 4'd0);
      chk_a("pushpop", 1, 2, 32'hD);
      chk("pushpop ovf", 32'(a_ovf), 32'd0);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 3'd0, 4'd0);
      chk_a("pushpop below", 0, 1, 32'hA);

      // reset mid-sequence dominates push, pop and restore
      RST = 1'b1;
      cyc_a(1'b1, 31'h77, 1'b1, 1'b1, 3'd3, 4'd4);
      RST = 1'b0;
      chk_a("midrst", 7, 0, 0);
      chk("midrst empty", 32'(a_pop_empty), 32'd1);
      // entry 0 was 0xA before reset and must now read zero
      cyc_a(1'b0, '0, 1'b0, 1'b1, 3'd0, 4'd1);
      chk("midrst entry0", 32'(a_pop_target), 32'd0);

      // push + pop at count 0 yields count 1, pointer unchanged
      do_reset();
      cyc_a(1'b1, 31'h55, 1'b1, 1'b0, 3'd0, 4'd0);
      chk_a("pushpop empty", 7, 1, 32'h55);
      chk("pushpop empty unf", 32'(a_unf), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
